risc0_segment_ctrl: RTL and testbench
=====================================

RISC0_SEGMENT_CTRL -- requirements
Module: risc0_segment_ctrl

Interface
REQ-001 Parameters (name, default, meaning): FLUSH_TIMEOUT, 256, max cycles to wait for seg_flush_ack; SEGW, 16, segment_count width.
REQ-002 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start_execution  in  1  start/restart request, level sampled each cycle
- segment_threshold  in  32  user cycles per segment; 0 = no segmentation
- max_cycles  in  32  total-cycle budget; 0 = unlimited
- core_step  in  1  one user cycle retired by executor
- core_halt  in  1  executor reached terminating ecall
- core_fault  in  1  executor illegal instruction or memory fault
- core_pc  in  32  executor PC
- core_run  out  1  enables executor stepping
- seg_flush_req  out  1  request segment commit
- seg_flush_ack  in  1  segment commit complete, one-cycle pulse
- execution_done  out  1  normal completion, held
- execution_error  out  1  abnormal completion, held
- err_code  out  2  0 none, 1 fault, 2 cycle budget, 3 flush timeout
- user_cycles  out  64  core_step count
- total_cycles  out  64  cycles spent in RUN/FLUSH/FINAL_FLUSH
- segment_count  out  SEGW  committed segments
- current_pc  out  32  registered core_pc, updated while core_run=1

Function
REQ-004 States: IDLE, RUN, FLUSH, FINAL_FLUSH, DONE, ERROR.
REQ-005 IDLE/DONE/ERROR + start_execution=1: latch segment_threshold and max_cycles; clear counters, err_code, done/error; next state RUN.
REQ-006 core_run SHALL be 1 only in RUN, asserted the cycle after the start sample.
REQ-007 In RUN/FLUSH/FINAL_FLUSH, total_cycles increments by 1 per cycle; core_step increments user_cycles and the internal seg_cycles only while core_run=1.
REQ-008 RUN event priority per cycle: core_fault (ERROR, code 1) > budget (max_cycles!=0 and total_cycles+1==max_cycles: ERROR, code 2) > core_halt (FINAL_FLUSH) > segment (threshold!=0, core_step, seg_cycles+1==threshold: FLUSH).
REQ-009 A core_step coincident with any RUN exit SHALL still be counted.
REQ-010 FLUSH/FINAL_FLUSH: seg_flush_req held 1 until the cycle seg_flush_ack=1; on ack segment_count+1, seg_cycles cleared; FLUSH -> RUN, FINAL_FLUSH -> DONE.
REQ-011 seg_flush_ack outside FLUSH/FINAL_FLUSH SHALL be ignored.
REQ-012 No ack within FLUSH_TIMEOUT cycles of entering flush: ERROR, code 3, seg_flush_req dropped.
REQ-013 core_fault in flush states SHALL go to ERROR code 1; core_halt in FLUSH SHALL be remembered and FLUSH then exits to DONE.
REQ-014 execution_done and execution_error are mutually exclusive and hold until the next start.
REQ-015 user_cycles, total_cycles and segment_count SHALL saturate at all-ones, never wrap.
REQ-016 start_execution in RUN/FLUSH/FINAL_FLUSH SHALL be ignored.

Reset
REQ-017 rst_n low: state IDLE; all outputs 0 (core_run, seg_flush_req, execution_done, execution_error, err_code, counters, current_pc); latched thresholds 0.
REQ-018 Reset mid-RUN or mid-flush SHALL abort immediately with no further seg_flush_req; leaving reset does not restart execution without a start sample.

Structure
REQ-019 State enum, err_code values and FLUSH_TIMEOUT default SHALL live in shared package risc0_fpga_pkg.
REQ-020 The saturating 64-bit counter SHALL be sub-module risc0_sat_counter (clear, inc, value), instantiated for user_cycles and total_cycles.

Verification
REQ-021 threshold=0, max=0, 10 core_step then core_halt, ack 3 cycles later -> execution_done=1, user_cycles=10, segment_count=1, err_code=0.
REQ-022 threshold=4, 10 steps, each flush acked after 2 cycles, halt after step 10 -> exactly 2 mid-run flushes plus final, segment_count=3, core_run=0 during each flush.
REQ-023 max_cycles=20, continuous core_step -> execution_error=1, err_code=2, total_cycles=20.
REQ-024 threshold=2, never ack -> ERROR with err_code=3 exactly 256 cycles after FLUSH entry.
REQ-025 core_fault and core_halt in same RUN cycle -> err_code=1, no seg_flush_req.
REQ-026 rst_n low during FLUSH, then high, then start -> all outputs 0 after reset, fresh run with counters from 0.

Source files
------------

// File: rtl/risc0_fpga_pkg.sv
// Shared types and defaults for the RISC0 segment controller: FSM states,
// completion codes and the flush-acknowledge timeout.
package risc0_fpga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RUN         = 3'd1,
        ST_FLUSH       = 3'd2,
        ST_FINAL_FLUSH = 3'd3,
        ST_DONE        = 3'd4,
        ST_ERROR       = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_FAULT   = 2'd1,
        ERR_BUDGET  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam int unsigned FLUSH_TIMEOUT_DEF = 256;

endpackage

// File: rtl/risc0_sat_counter.sv
// Counter that clears synchronously and sticks at all-ones instead of wrapping.
module risc0_sat_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc && (value_q != {W{1'b1}})) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/risc0_segment_ctrl.sv
// Sequences a zkVM executor through run, segment-commit flushes and final
// commit, tracking cycle budgets and reporting how execution ended.
//
// state          | meaning
// ST_IDLE        | post-reset, waiting for start_execution
// ST_RUN         | executor stepping (core_run=1)
// ST_FLUSH       | mid-run segment commit, waiting for ack
// ST_FINAL_FLUSH | last segment commit after halt
// ST_DONE        | normal completion, held until next start
// ST_ERROR       | abnormal completion, err_code valid
module risc0_segment_ctrl
    import risc0_fpga_pkg::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF,
    parameter int unsigned SEGW          = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_execution,
    input  logic [31:0]     segment_threshold,
    input  logic [31:0]     max_cycles,
    input  logic            core_step,
    input  logic            core_halt,
    input  logic            core_fault,
    input  logic [31:0]     core_pc,
    output logic            core_run,
    output logic            seg_flush_req,
    input  logic            seg_flush_ack,
    output logic            execution_done,
    output logic            execution_error,
    output logic [1:0]      err_code,
    output logic [63:0]     user_cycles,
    output logic [63:0]     total_cycles,
    output logic [SEGW-1:0] segment_count,
    output logic [31:0]     current_pc
);

    state_e      state_q, state_d;
    logic [31:0] thr_q, thr_d;
    logic [31:0] max_q, max_d;
    logic [31:0] seg_cyc_q, seg_cyc_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] pc_q, pc_d;
    err_e        err_q, err_d;
    logic        halt_pend_q, halt_pend_d;

    logic in_run;
    logic in_flush;
    logic cnt_clear;
    logic seg_inc;
    logic budget_hit;
    logic seg_hit;

    assign in_run   = (state_q == ST_RUN);
    assign in_flush = (state_q == ST_FLUSH) || (state_q == ST_FINAL_FLUSH);

    // total_cycles still holds the pre-increment value this cycle.
    assign budget_hit = (max_q != 32'd0) && ((total_cycles + 64'd1) == {32'd0, max_q});
    assign seg_hit    = (thr_q != 32'd0) && core_step && ((seg_cyc_q + 32'd1) == thr_q);

    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        max_d       = max_q;
        seg_cyc_d   = seg_cyc_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        halt_pend_d = halt_pend_q;
        pc_d        = pc_q;
        cnt_clear   = 1'b0;
        seg_inc     = 1'b0;

        if (in_run) begin
            pc_d = core_pc;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_execution) begin
                    cnt_clear   = 1'b1;
                    thr_d       = segment_threshold;
                    max_d       = max_cycles;
                    seg_cyc_d   = 32'd0;
                    err_d       = ERR_NONE;
                    halt_pend_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_step) begin
                    seg_cyc_d = seg_cyc_q + 32'd1;
                end
                if (core_fault) begin
                    err_d   = ERR_FAULT;
                    state_d = ST_ERROR;
                end else if (budget_hit) begin
                    err_d   = ERR_BUDGET;
                    state_d = ST_ERROR;
                end else if (core_halt) begin
                    tmo_d   = 32'(FLUSH_TIMEOUT - 1);
                    state_d = ST_FINAL_FLUSH;
                end else if (seg_hit) begin
                    tmo_d   = 32'(FLUSH_TIMEOUT - 1);
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH, ST_FINAL_FLUSH: begin
                if ((state_q == ST_FLUSH) && core_halt) begin
                    halt_pend_d = 1'b1;
                end
                if (core_fault) begin
                    err_d   = ERR_FAULT;
                    state_d = ST_ERROR;
                end else if (seg_flush_ack) begin
                    seg_inc     = 1'b1;
                    seg_cyc_d   = 32'd0;
                    halt_pend_d = 1'b0;
                    if ((state_q == ST_FINAL_FLUSH) || halt_pend_q || core_halt) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (tmo_q == 32'd0) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            thr_q       <= 32'd0;
            max_q       <= 32'd0;
            seg_cyc_q   <= 32'd0;
            tmo_q       <= 32'd0;
            err_q       <= ERR_NONE;
            halt_pend_q <= 1'b0;
            pc_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            max_q       <= max_d;
            seg_cyc_q   <= seg_cyc_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            halt_pend_q <= halt_pend_d;
            pc_q        <= pc_d;
        end
    end

    risc0_sat_counter #(.W(64)) u_user_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (core_step && in_run),
        .value (user_cycles)
    );

    risc0_sat_counter #(.W(64)) u_total_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (in_run || in_flush),
        .value (total_cycles)
    );

    risc0_sat_counter #(.W(SEGW)) u_seg_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (seg_inc),
        .value (segment_count)
    );

    assign core_run        = in_run;
    assign seg_flush_req   = in_flush;
    assign execution_done  = (state_q == ST_DONE);
    assign execution_error = (state_q == ST_ERROR);
    assign err_code        = err_q;
    assign current_pc      = pc_q;

endmodule

// File: tb/tb_risc0_segment_ctrl.sv
// Directed bench for risc0_segment_ctrl: a table of whole-run scenarios driven
// by a reactive executor/commit model, plus hand sequences for corner cases.
module tb_risc0_segment_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_execution;
    logic [31:0] segment_threshold;
    logic [31:0] max_cycles;
    logic        core_step;
    logic        core_halt;
    logic        core_fault;
    logic [31:0] core_pc;
    logic        core_run;
    logic        seg_flush_req;
    logic        seg_flush_ack;
    logic        execution_done;
    logic        execution_error;
    logic [1:0]  err_code;
    logic [63:0] user_cycles;
    logic [63:0] total_cycles;
    logic [15:0] segment_count;
    logic [31:0] current_pc;

    risc0_segment_ctrl #(.FLUSH_TIMEOUT(256), .SEGW(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_execution   (start_execution),
        .segment_threshold (segment_threshold),
        .max_cycles        (max_cycles),
        .core_step         (core_step),
        .core_halt         (core_halt),
        .core_fault        (core_fault),
        .core_pc           (core_pc),
        .core_run          (core_run),
        .seg_flush_req     (seg_flush_req),
        .seg_flush_ack     (seg_flush_ack),
        .execution_done    (execution_done),
        .execution_error   (execution_error),
        .err_code          (err_code),
        .user_cycles       (user_cycles),
        .total_cycles      (total_cycles),
        .segment_count     (segment_count),
        .current_pc        (current_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [31:0] thr;
        logic [31:0] maxc;
        int          n_steps;
        bit          halt;
        int          ack_dly;
        bit          noise;
        bit          exp_done;
        bit          exp_err;
        logic [1:0]  exp_code;
        logic [63:0] exp_user;
        logic [63:0] exp_total;
        int          exp_seg;
        int          exp_req_cyc;
        int          exp_nflush;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic [31:0] thr, input logic [31:0] maxc, input int n,
                                input bit halt, input int dly, input bit noise, input bit d,
                                input bit e, input logic [1:0] code, input logic [63:0] u,
                                input logic [63:0] t, input int seg, input int reqc, input int nf);
        vec_t v;
        v.thr = thr; v.maxc = maxc; v.n_steps = n; v.halt = halt; v.ack_dly = dly;
        v.noise = noise; v.exp_done = d; v.exp_err = e; v.exp_code = code;
        v.exp_user = u; v.exp_total = t; v.exp_seg = seg; v.exp_req_cyc = reqc; v.exp_nflush = nf;
        return v;
    endfunction

    task automatic clear_inputs();
        start_execution = 1'b0;
        core_step       = 1'b0;
        core_halt       = 1'b0;
        core_fault      = 1'b0;
        seg_flush_ack   = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] thr, input logic [31:0] maxc);
        @(negedge clk);
        segment_threshold = thr;
        max_cycles        = maxc;
        start_execution   = 1'b1;
        @(negedge clk);
        start_execution   = 1'b0;
    endtask

    // Executor steps while core_run, halts once its steps are used up; the
    // commit side acks on the (ack_dly+1)-th cycle of each flush request.
    task automatic run_vec(input vec_t v, input int idx);
        int    steps = 0;
        int    wait_cnt = 0;
        int    req_cyc = 0;
        int    nflush = 0;
        int    viol = 0;
        bit    prev_req = 1'b0;
        bit    finished = 1'b0;
        logic [31:0] last_pc = 32'd0;
        string tag;
        start_run(v.thr, v.maxc);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (execution_done || execution_error) begin
                finished = 1'b1;
                break;
            end
            core_step = 1'b0; core_halt = 1'b0; seg_flush_ack = 1'b0;
            if (core_run) begin
                if (steps < v.n_steps) begin
                    core_step = 1'b1;
                    steps++;
                    core_pc = 32'h1000 + 32'(steps * 4);
                    last_pc = core_pc;
                end else if (v.halt) begin
                    core_halt = 1'b1;
                end
            end
            if (seg_flush_req) begin
                req_cyc++;
                if (!prev_req) nflush++;
                if (core_run) viol++;
                if (v.noise) core_step = 1'b1;
                if (wait_cnt == v.ack_dly) begin
                    seg_flush_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            prev_req = seg_flush_req;
            @(negedge clk);
        end
        clear_inputs();
        tag = $sformatf("v%0d", idx);
        check({tag, "_finished"}, 64'(finished), 64'd1);
        check({tag, "_done"}, 64'(execution_done), 64'(v.exp_done));
        check({tag, "_error"}, 64'(execution_error), 64'(v.exp_err));
        check({tag, "_err_code"}, 64'(err_code), 64'(v.exp_code));
        check({tag, "_user_cycles"}, user_cycles, v.exp_user);
        check({tag, "_total_cycles"}, total_cycles, v.exp_total);
        check({tag, "_segment_count"}, 64'(segment_count), 64'(v.exp_seg));
        check({tag, "_req_cycles"}, 64'(req_cyc), 64'(v.exp_req_cyc));
        check({tag, "_flushes"}, 64'(nflush), 64'(v.exp_nflush));
        check({tag, "_run_during_flush"}, 64'(viol), 64'd0);
        check({tag, "_core_run_after"}, 64'(core_run), 64'd0);
        check({tag, "_current_pc"}, 64'(current_pc), 64'(last_pc));
    endtask

    initial begin
        //              thr  max   n  halt dly  nz  done err code user total seg reqc nfl
        vecs[0] = mk(0,  0,  10,  1,   3,  0,  1,  0,  0,  10,  15,   1,  4,   1);
        vecs[1] = mk(4,  0,  10,  1,   2,  1,  1,  0,  0,  10,  20,   3,  9,   3);
        vecs[2] = mk(0,  20, 1000, 0,  0,  0,  0,  1,  2,  20,  20,   0,  0,   0);
        vecs[3] = mk(2,  0,  1000, 0,  100000, 0, 0, 1, 3,  2,  258,  0,  256, 1);
        vecs[4] = mk(3,  0,  5,   1,   0,  0,  1,  0,  0,  5,   8,    2,  2,   2);
        vecs[5] = mk(0,  1,  1000, 0,  0,  0,  0,  1,  2,  1,   1,    0,  0,   0);
        vecs[6] = mk(1,  0,  3,   1,   1,  0,  1,  0,  0,  3,   12,   4,  8,   4);
        vecs[7] = mk(2,  0,  2,   1,   255, 0, 1,  0,  0,  2,   515,  2,  512, 2);
        vecs[8] = mk(0,  0,  3,   1,   0,  0,  1,  0,  0,  3,   5,    1,  1,   1);

        rst_n = 1'b0;
        segment_threshold = 32'd0;
        max_cycles = 32'd0;
        core_pc = 32'd0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("reset_core_run", 64'(core_run), 64'd0);
        check("reset_flush_req", 64'(seg_flush_req), 64'd0);
        check("reset_done_error", 64'({execution_done, execution_error, err_code}), 64'd0);
        check("reset_counters", user_cycles | total_cycles | 64'(segment_count) | 64'(current_pc), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_autostart", 64'(core_run), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // core_fault and core_halt together: fault wins, no commit
        start_run(32'd0, 32'd0);
        core_fault = 1'b1; core_halt = 1'b1; core_step = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("fh_error", 64'(execution_error), 64'd1);
        check("fh_done", 64'(execution_done), 64'd0);
        check("fh_err_code", 64'(err_code), 64'd1);
        check("fh_flush_req", 64'(seg_flush_req), 64'd0);
        check("fh_step_counted", user_cycles, 64'd1);
        @(negedge clk);
        check("fh_flush_req_later", 64'(seg_flush_req), 64'd0);

        // halt during mid-run flush is remembered: ack leads to DONE
        start_run(32'd1, 32'd0);
        core_step = 1'b1;
        @(negedge clk);
        core_step = 1'b0;
        check("hf_in_flush", 64'(seg_flush_req), 64'd1);
        core_halt = 1'b1;
        @(negedge clk);
        core_halt = 1'b0;
        @(negedge clk);
        seg_flush_ack = 1'b1;
        @(negedge clk);
        seg_flush_ack = 1'b0;
        check("hf_done", 64'(execution_done), 64'd1);
        check("hf_core_run", 64'(core_run), 64'd0);
        check("hf_segment_count", 64'(segment_count), 64'd1);
        check("hf_err_code", 64'(err_code), 64'd0);

        // fault during flush, coincident with ack: fault wins
        start_run(32'd1, 32'd0);
        core_step = 1'b1;
        @(negedge clk);
        core_step = 1'b0;
        core_fault = 1'b1;
        seg_flush_ack = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("ff_error", 64'(execution_error), 64'd1);
        check("ff_err_code", 64'(err_code), 64'd1);
        check("ff_segment_count", 64'(segment_count), 64'd0);

        // stray ack and start in RUN are ignored; current_pc follows core_pc only in RUN
        start_run(32'd0, 32'd0);
        core_step = 1'b1; core_pc = 32'h0000_0040; seg_flush_ack = 1'b1; start_execution = 1'b1;
        @(negedge clk);
        core_pc = 32'h0000_0044; seg_flush_ack = 1'b0; start_execution = 1'b0;
        check("st_core_run", 64'(core_run), 64'd1);
        check("st_stray_ack", 64'(segment_count), 64'd0);
        check("st_pc", 64'(current_pc), 64'h40);
        @(negedge clk);
        core_step = 1'b0;
        check("st_start_ignored", user_cycles, 64'd2);
        check("st_total", total_cycles, 64'd2);
        core_halt = 1'b1;
        @(negedge clk);
        core_halt = 1'b0;
        seg_flush_ack = 1'b1;
        @(negedge clk);
        seg_flush_ack = 1'b0;
        core_pc = 32'h0000_0099;
        check("st_done", 64'(execution_done), 64'd1);
        @(negedge clk);
        check("st_pc_frozen", 64'(current_pc), 64'h44);
        check("st_done_held", 64'(execution_done), 64'd1);

        // reset in the middle of a flush aborts, then a fresh run starts from zero
        start_run(32'd2, 32'd0);
        core_step = 1'b1;
        repeat (2) @(negedge clk);
        core_step = 1'b0;
        check("rf_in_flush", 64'(seg_flush_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rf_req_async", 64'(seg_flush_req), 64'd0);
        check("rf_outputs_zero", 64'({core_run, execution_done, execution_error, err_code}), 64'd0);
        check("rf_counters_zero", user_cycles | total_cycles | 64'(segment_count) | 64'(current_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rf_no_restart", 64'({core_run, seg_flush_req}), 64'd0);
        run_vec(vecs[8], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
